zcomb_arbiter: RTL

Round-robin scheduler that shares one z-combiner datapath (inputs x/y, output z, internal synchronously-reset Moore state) between NREQ requesters. The block grants the datapath to one requester at a time and pulses the datapath reset at the start of each grant, so every burst sees a clean state. It forwards that requester's x/y beats and returns the sampled z per beat, tagged with the requester id. It sits between the requester ports and the single datapath instance.

---
 rtl/zcomb_arbiter_if.sv | 34 +++
 rtl/zcomb_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/zcomb_arbiter_if.sv
// Requester-side and datapath-side signals of the z-combiner arbiter.
// The slave modport is the arbiter's view; the master modport is the
// environment's view (requesters plus the shared datapath).
interface zcomb_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_x;
    logic [NREQ-1:0] req_y;
    logic [NREQ-1:0] req_last;
    logic [NREQ-1:0] gnt;
    logic            net_x;
    logic            net_y;
    logic            net_reset;
    logic            net_z;
    logic            rsp_valid;
    logic            rsp_z;
    logic [IDW-1:0]  rsp_id;
    logic            rsp_last;
    logic            rsp_abort;

    modport slave (
        input  req_valid, req_x, req_y, req_last, net_z,
        output gnt, net_x, net_y, net_reset,
               rsp_valid, rsp_z, rsp_id, rsp_last, rsp_abort
    );

    modport master (
        output req_valid, req_x, req_y, req_last, net_z,
        input  gnt, net_x, net_y, net_reset,
               rsp_valid, rsp_z, rsp_id, rsp_last, rsp_abort
    );
endinterface

// File: rtl/zcomb_arbiter.sv
// Round-robin owner of a single z-combiner datapath. Each grant starts with
// one datapath reset cycle, then forwards the owner's x/y beats and returns
// the sampled z per beat tagged with the owner id. An owner that stays idle
// for TIMEOUT RUN cycles loses its grant and an abort pulse is reported.
module zcomb_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    zcomb_arbiter_if.slave  bus_if
);
    localparam int IDW  = $clog2(NREQ);
    localparam int CNTW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NRST = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t          state_q;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  own_q;
    logic [NREQ-1:0] gnt_q;
    logic [CNTW-1:0] idle_q;
    logic            rsp_valid_q;
    logic            rsp_z_q;
    logic [IDW-1:0]  rsp_id_q;
    logic            rsp_last_q;
    logic            rsp_abort_q;

    logic            pick_found_s;
    logic [IDW-1:0]  pick_idx_s;
    logic [IDW:0]    sum_s;
    logic [IDW-1:0]  cand_s;
    logic            hit_s;
    logic            accept_s;
    logic            beat_last_s;
    logic            timeout_s;
    logic [IDW-1:0]  next_ptr_s;

    // Rotating priority scan: first pending requester at or after ptr, with wrap.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        sum_s        = '0;
        cand_s       = '0;
        hit_s        = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            sum_s        = {1'b0, ptr_q} + (IDW+1)'(k);
            sum_s        = (sum_s >= (IDW+1)'(NREQ)) ? (sum_s - (IDW+1)'(NREQ)) : sum_s;
            cand_s       = sum_s[IDW-1:0];
            hit_s        = !pick_found_s && bus_if.req_valid[cand_s];
            pick_idx_s   = hit_s ? cand_s : pick_idx_s;
            pick_found_s = pick_found_s | hit_s;
        end
    end

    // Beat acceptance, end-of-burst and idle-timeout decisions for the current owner.
    always_comb begin
        accept_s    = (state_q == ST_RUN) && bus_if.req_valid[own_q];
        beat_last_s = accept_s && bus_if.req_last[own_q];
        timeout_s   = (state_q == ST_RUN) && !accept_s && (idle_q == CNTW'(TIMEOUT - 1));
        next_ptr_s  = (own_q == IDW'(NREQ - 1)) ? IDW'(0) : (own_q + IDW'(1));
    end

    // Grant FSM, idle counter and registered response channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            own_q       <= '0;
            gnt_q       <= '0;
            idle_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_z_q     <= 1'b0;
            rsp_id_q    <= '0;
            rsp_last_q  <= 1'b0;
            rsp_abort_q <= 1'b0;
        end else begin
            rsp_valid_q <= accept_s;
            rsp_last_q  <= beat_last_s;
            rsp_abort_q <= timeout_s;
            if (accept_s) begin
                rsp_z_q  <= bus_if.net_z;
                rsp_id_q <= own_q;
            end else if (timeout_s) begin
                rsp_id_q <= own_q;
            end

            case (state_q)
                ST_IDLE: begin
                    idle_q <= '0;
                    if (pick_found_s) begin
                        gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
                        own_q   <= pick_idx_s;
                        state_q <= ST_NRST;
                    end else begin
                        gnt_q <= '0;
                    end
                end
                ST_NRST: begin
                    idle_q  <= '0;
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (beat_last_s || timeout_s) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                        ptr_q   <= next_ptr_s;
                        idle_q  <= '0;
                    end else if (accept_s) begin
                        idle_q <= '0;
                    end else if (idle_q != CNTW'(TIMEOUT)) begin
                        idle_q <= idle_q + CNTW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    idle_q  <= '0;
                end
            endcase
        end
    end

    // The hold input (0,0) is presented whenever no beat is being accepted.
    assign bus_if.net_x     = accept_s && bus_if.req_x[own_q];
    assign bus_if.net_y     = accept_s && bus_if.req_y[own_q];
    assign bus_if.net_reset = reset || (state_q == ST_NRST);
    assign bus_if.gnt       = gnt_q;
    assign bus_if.rsp_valid = rsp_valid_q;
    assign bus_if.rsp_z     = rsp_z_q;
    assign bus_if.rsp_id    = rsp_id_q;
    assign bus_if.rsp_last  = rsp_last_q;
    assign bus_if.rsp_abort = rsp_abort_q;
endmodule
